// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared types and constants for the common data bus (CDB) arbiter slice.
//   - DATA_WIDTH / ROB_DEPTH_BITS : broadcast value width and ROB tag width
//   - CDB_NUM_REQ                 : number of completing units sharing the CDB
//   - cdb_unit_e                  : index of each completing unit on the arbiter
//   - cdb_req_t                   : one unit's completion request {valid, tag, data}
//   - next_rr()                   : round-robin successor with an explicit wrap compare
package cdb_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ROB_DEPTH_BITS = 5;
  localparam int CDB_NUM_REQ    = 3;

  typedef enum logic [1:0] {
    CDB_ALU  = 2'd0,
    CDB_LOAD = 2'd1,
    CDB_MULT = 2'd2
  } cdb_unit_e;

  typedef struct packed {
    logic                      valid;
    logic [ROB_DEPTH_BITS-1:0] tag;
    logic [DATA_WIDTH-1:0]     data;
  } cdb_req_t;

  // NUM_REQ need not be a power of two, so the wrap is an explicit compare
  // instead of relying on the index register overflowing.
  function automatic int next_rr(input int idx, input int num_req);
    return (idx >= num_req - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if
//   Request/broadcast bundle between the completing units and the CDB arbiter.
//   - req_valid / req_tag / req_data : per-unit results, unit i at slice i
//   - req_ready                      : one-hot grant back to the units
//   - cdb_valid / cdb_tag / cdb_data : registered broadcast to ROB and RS
//   Modports: master = units + CDB consumers, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_REQ    = cdb_arbiter_pkg::CDB_NUM_REQ,
  parameter int TAG_BITS   = cdb_arbiter_pkg::ROB_DEPTH_BITS,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*TAG_BITS-1:0]   req_tag;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cdb_valid;
  logic [TAG_BITS-1:0]           cdb_tag;
  logic [DATA_WIDTH-1:0]         cdb_data;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter
//   Pure combinational round-robin picker.
//   - req       in  : request vector
//   - ptr       in  : highest-priority index this cycle
//   - grant     out : one-hot grant (all zero when nothing requests)
//   - grant_idx out : binary index of the granted request
//   - grant_any out : some request was granted
module rr_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int IDX_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_any
);

  int cand;

  // Scan ptr, ptr+1, ... wrapping at NUM_REQ; the first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_BITS'(cand);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Shares the single common data bus among NUM_REQ completing units with a
//   round-robin grant and a registered one-per-cycle broadcast.
//   Ports:
//   - clk        in  : clock
//   - rst_n      in  : synchronous active-low reset
//   - flush      in  : branch mispredict flush, kills all in-flight traffic
//   - bus        slave modport of cdb_arbiter_if (requests, grant, broadcast)
//   - stall_cnt  out : per-unit lost-arbitration counters, present only when
//                      CDB_PERF_CNT_EN is defined
//   Optional feature macro: CDB_PERF_CNT_EN
module cdb_arbiter #(
  parameter int NUM_REQ    = cdb_arbiter_pkg::CDB_NUM_REQ,
  parameter int DATA_WIDTH = cdb_arbiter_pkg::DATA_WIDTH,
  parameter int TAG_BITS   = cdb_arbiter_pkg::ROB_DEPTH_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  cdb_arbiter_if.slave      bus
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [NUM_REQ*32-1:0] stall_cnt
`endif
);

  import cdb_arbiter_pkg::*;

  localparam int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_BITS-1:0] rr_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_BITS-1:0] grant_idx;
  logic                grant_any;

  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_BITS (IDX_BITS)
  ) u_rr_arbiter (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Flush suppresses every grant so no unit believes its result was taken.
  assign bus.req_ready = flush ? '0 : grant;

  // Output register and pointer. Reset beats flush; a flush drops whatever
  // would have been registered this cycle and restarts priority at unit 0.
  // When idle, tag/data keep their last value and only valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cdb_valid <= 1'b0;
      bus.cdb_tag   <= '0;
      bus.cdb_data  <= '0;
      rr_ptr        <= '0;
    end else if (flush) begin
      bus.cdb_valid <= 1'b0;
      rr_ptr        <= '0;
    end else if (grant_any) begin
      bus.cdb_valid <= 1'b1;
      bus.cdb_tag   <= bus.req_tag[int'(grant_idx)*TAG_BITS +: TAG_BITS];
      bus.cdb_data  <= bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
      rr_ptr        <= IDX_BITS'(next_rr(int'(grant_idx), NUM_REQ));
    end else begin
      bus.cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_PERF_CNT_EN
  // A unit stalls when it has a result but lost arbitration. Flush cycles are
  // not stalls. Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && !bus.req_ready[i] && !flush &&
            (stall_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter: directed scenarios followed by
//   randomized traffic, all compared against a behavioural model of the
//   round-robin CDB. Build with CDB_PERF_CNT_EN to also cover stall counters.
module tb_cdb_arbiter;

  import cdb_arbiter_pkg::*;

  localparam int NUM_REQ  = CDB_NUM_REQ;
  localparam int TAG_BITS = ROB_DEPTH_BITS;
  localparam int DW       = DATA_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_BITS(TAG_BITS), .DATA_WIDTH(DW)) bus ();

`ifdef CDB_PERF_CNT_EN
  logic [NUM_REQ*32-1:0] stall_cnt;
`endif

  cdb_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DW),
    .TAG_BITS   (TAG_BITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef CDB_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Pending result of each unit, held until the unit sees its grant.
  bit                u_valid [NUM_REQ];
  logic [TAG_BITS-1:0] u_tag [NUM_REQ];
  logic [DW-1:0]     u_data  [NUM_REQ];

  // Reference model: priority start, what the CDB shows, stall totals.
  int                m_ptr = 0;
  logic              m_valid = 1'b0;
  logic [TAG_BITS-1:0] m_tag = '0;
  logic [DW-1:0]     m_data = '0;
  longint unsigned   m_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] obs_ready;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First pending unit found walking forward from m_ptr, -1 if none.
  function automatic int modelPick();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (u_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Adds requests for the units in mask that are idle; pending ones keep
  // their tag/data untouched.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (mask[i] && !u_valid[i]) begin
        u_valid[i] = 1'b1;
        u_tag[i]   = TAG_BITS'($urandom);
        u_data[i]  = DW'($urandom);
      end
    end
  endtask

  task automatic clearUnits();
    for (int i = 0; i < NUM_REQ; i++) u_valid[i] = 1'b0;
  endtask

  // One full clock: drive at negedge, check the grant, let the edge happen,
  // advance the model, then check the registered broadcast.
  task automatic runCycle(input logic do_flush, input logic do_rst);
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    @(negedge clk);
    rst_n = !do_rst;
    flush = do_flush;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_valid[i]                     = u_valid[i];
      bus.req_tag[i*TAG_BITS +: TAG_BITS]  = u_tag[i];
      bus.req_data[i*DW +: DW]             = u_data[i];
    end
    #1;
    g = modelPick();
    exp_ready = '0;
    if (!do_flush && g >= 0) exp_ready[g] = 1'b1;
    obs_ready = bus.req_ready;
    if (!do_rst) checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    if (do_rst) begin
      for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    end else if (!do_flush) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (u_valid[i] && !exp_ready[i] && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i]++;
      end
    end
    if (do_rst) begin
      m_valid = 1'b0; m_tag = '0; m_data = '0; m_ptr = 0;
      clearUnits();
    end else if (do_flush) begin
      m_valid = 1'b0; m_ptr = 0;
      clearUnits();
    end else if (g >= 0) begin
      m_valid = 1'b1; m_tag = u_tag[g]; m_data = u_data[g];
      m_ptr = (g + 1) % NUM_REQ;
      u_valid[g] = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    checkOutput("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    checkOutput("cdb_tag",   64'(bus.cdb_tag),   64'(m_tag));
    checkOutput("cdb_data",  64'(bus.cdb_data),  64'(m_data));
`ifdef CDB_PERF_CNT_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      checkOutput($sformatf("stall_cnt%0d", i), 64'(stall_cnt[i*32 +: 32]), m_cnt[i]);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      u_valid[i] = 1'b0; u_tag[i] = '0; u_data[i] = '0; m_cnt[i] = 0;
    end
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;

    runCycle(1'b0, 1'b1);
    runCycle(1'b0, 1'b1);
    checkOutput("reset_valid", 64'(bus.cdb_valid), 64'd0);
    checkOutput("reset_tag",   64'(bus.cdb_tag),   64'd0);
    checkOutput("reset_data",  64'(bus.cdb_data),  64'd0);

    // Single request from the load unit.
    applyStimulus(3'b010);
    u_tag[CDB_LOAD]  = TAG_BITS'(5);
    u_data[CDB_LOAD] = 32'hDEAD_BEEF;
    runCycle(1'b0, 1'b0);
    checkOutput("t1_ready", 64'(obs_ready), 64'b010);
    checkOutput("t1_valid", 64'(bus.cdb_valid), 64'd1);
    checkOutput("t1_tag",   64'(bus.cdb_tag),   64'd5);
    checkOutput("t1_data",  64'(bus.cdb_data),  64'hDEAD_BEEF);

    // Pointer now at 2: units 0 and 1 request, grant wraps to unit 0.
    applyStimulus(3'b011);
    runCycle(1'b0, 1'b0);
    checkOutput("t3_wrap_grant", 64'(obs_ready), 64'b001);
    applyStimulus(3'b111);
    runCycle(1'b0, 1'b0);
    checkOutput("t3_ptr_after_wrap", 64'(obs_ready), 64'b010);

    // All units request from reset for 6 cycles.
    runCycle(1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b111);
      runCycle(1'b0, 1'b0);
      checkOutput($sformatf("t2_grant%0d", c), 64'(obs_ready), 64'(1 << (c % 3)));
      checkOutput($sformatf("t2_valid%0d", c), 64'(bus.cdb_valid), 64'd1);
    end

    // Flush with every unit requesting.
    applyStimulus(3'b111);
    runCycle(1'b1, 1'b0);
    checkOutput("t4_flush_ready", 64'(obs_ready), 64'd0);
    checkOutput("t4_flush_valid", 64'(bus.cdb_valid), 64'd0);
    applyStimulus(3'b111);
    runCycle(1'b0, 1'b0);
    checkOutput("t4_post_flush_grant", 64'(obs_ready), 64'b001);

    // Reset while a broadcast is on the bus, then release with nothing pending.
    applyStimulus(3'b110);
    runCycle(1'b0, 1'b1);
    checkOutput("t5_rst_valid", 64'(bus.cdb_valid), 64'd0);
    checkOutput("t5_rst_data",  64'(bus.cdb_data),  64'd0);
    runCycle(1'b0, 1'b0);
    checkOutput("t5_no_stale", 64'(bus.cdb_valid), 64'd0);

`ifdef CDB_PERF_CNT_EN
    // Units 0 and 1 compete for 4 cycles; each loses twice.
    runCycle(1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(3'b011);
      runCycle(1'b0, 1'b0);
    end
    checkOutput("t6_stall1", 64'(stall_cnt[32 +: 32]), 64'd2);
    // Preload near the top and keep unit 1 losing: it must stick at max.
    @(negedge clk);
    force dut.stall_cnt = {{(NUM_REQ-2){32'h0}}, 32'hFFFF_FFFE, 32'h0};
    #1;
    release dut.stall_cnt;
    for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    m_cnt[1] = 64'hFFFF_FFFE;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(3'b011);
      runCycle(1'b0, 1'b0);
    end
    checkOutput("t6_saturate", 64'(stall_cnt[32 +: 32]), 64'hFFFF_FFFF);
`endif

    // Randomized traffic with occasional flush and reset.
    runCycle(1'b0, 1'b1);
    for (int c = 0; c < 400; c++) begin
      applyStimulus(NUM_REQ'($urandom));
      runCycle($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
